bus_credit_arbiter: RTL and testbench
=====================================

Name: bus_credit_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared packet bus between `drvrs` driver FIFOs.
- Picks one pending source, pops one packet from it, and decodes the destination from the packet's top 8 bits.
- Pushes the packet to one destination FIFO, or to every FIFO except the source when the destination field equals `broadcast`.
- Pushes only when the destination FIFO(s) hold free space, tracked by per-destination credit counters. The block sits between the driver FIFO array and the receive FIFO array, alongside the existing bus generator.

Parameters:
- pckg_sz, 32, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID.
- drvrs, 16, number of drivers/receivers (2..255).
- broadcast, 8'hFF, destination ID meaning all drivers except the source.
- depth, 8, initial and maximum credits per destination (receive FIFO depth).
- max_burst, 4, maximum consecutive packets per grant; used only with BUS_WRR_EN.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- pndng, input, drvrs, driver FIFO non-empty flags.
- D_pop, input, drvrs*pckg_sz, driver FIFO head data (first-word fall-through), slice i = driver i.
- pop, output, drvrs, one-hot pop strobe.
- D_push, output, pckg_sz, packet data to receivers.
- push, output, drvrs, push strobes; one-hot for unicast, multi-hot for broadcast.
- credit_rtn, input, drvrs, one-cycle pulse per word drained from receive FIFO i.
- grant_id, output, 8, index of current/last granted driver.
- busy, output, 1, high in any state other than IDLE.
- drop_cnt, output, 16, count of dropped packets, saturating.

Behaviour:
- Reset values: pop=0, push=0, D_pop capture register=0, D_push=0, grant_id=drvrs-1 (so driver 0 is first priority), busy=0, drop_cnt=0, all credits=depth, state=IDLE. Reset mid-packet aborts the transfer; no push is issued.
- FSM IDLE -> POP -> DELIVER -> IDLE.
- IDLE:
  - If any pndng bit is set, select the first set bit searching upward from grant_id+1 with wrap-around.
  - Register grant_id and go to POP. Otherwise remain in IDLE.
- POP (one cycle):
  - pop[grant_id]=1.
  - Capture the D_pop slice into the packet register on the clock edge.
  - Go to DELIVER.
- DELIVER, destination decode:
  - dest==broadcast: target set = all drivers except grant_id.
  - dest<drvrs and dest!=grant_id: target = dest.
  - Otherwise (out of range, or self-addressed): drop. drop_cnt increments (saturates at 16'hFFFF), no push, return to IDLE.
- DELIVER, send:
  - If every target credit > 0: assert push on the target set with D_push = packet for exactly one cycle, decrement those credits, return to IDLE.
  - Else stall in DELIVER with push=0 until credits arrive. There is no timeout and no partial broadcast.
- Latency: pndng seen at edge k -> pop high in cycle k+1 -> push high in cycle k+2 if credits are available. Minimum 3 cycles per packet.
- Credits:
  - Per-destination counter, width clog2(depth+1).
  - credit_rtn increments the counter, saturating at depth.
  - Push and credit_rtn on the same destination in the same cycle leave the count unchanged.
  - A credit_rtn pulse while a counter is at depth is ignored.
- pndng changing after grant has no effect. pop is never issued to a driver whose pndng was low in the grant cycle.

Optional Feature:
- Macro BUS_WRR_EN.
- Defined:
  - From DELIVER, after a successful push or drop, return to POP on the same grant_id if pndng[grant_id] is still set and fewer than max_burst packets have been sent in this grant; otherwise go to IDLE.
  - The burst counter resets on every new grant.
- Undefined: strict one packet per grant; max_burst is ignored.

Decomposition:
- Shared package bus_arb_pkg:
  - state enum {IDLE, POP, DELIVER}.
  - Destination-field helper constants DEST_MSB and DEST_LSB.
  - Default broadcast constant.
- One natural sub-module, rr_pick: combinational round-robin priority search over drvrs requests given a last-grant index. It outputs a valid flag and the index.
- The credit counters stay inline.

Test Plan:
- Single unicast, drvrs=4: pndng=4'b0001, D_pop[0]=32'h02AB_CDEF -> pop[0] in cycle 1; push=4'b0100 and D_push=32'h02AB_CDEF in cycle 2; credit[2]=7.
- Round-robin fairness: pndng=4'b1111 held, all destinations valid -> grant order 0,1,2,3,0.
- Broadcast from driver 1, D_pop[1]=32'hFF00_0011 -> push=4'b1101 for exactly one cycle; credits 0, 2 and 3 decrement.
- Credit stall: drain credit[3] to 0 with 8 pushes, then send a packet to dest 3 -> busy stays high with push=0; one credit_rtn[3] pulse -> push[3] the next cycle.
- Invalid and self destinations: dest=8'h09 (drvrs=4), then a packet from driver 2 with dest=2 -> no push for either, drop_cnt=2.
- Reset mid-DELIVER during a stall -> all outputs and credits return to their reset values immediately (asynchronous); with BUS_WRR_EN and max_burst=2, driver 0 gets 2 consecutive packets before driver 1 is granted.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the packet-bus credit arbiter.
// Destination field sits in the top DEST_W bits of every packet.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DELIVER
    } state_t;

    // Field position for a 32-bit packet; width drives wider/narrower packets.
    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 24;
    localparam int DEST_W   = DEST_MSB - DEST_LSB + 1;

    localparam logic [7:0] BCAST_DEF = 8'hFF;

endpackage

// File: rtl/bus_credit_arbiter_rr_pick.sv
// Combinational round-robin search over N requests.
// Returns the first set request above i_last, wrapping around.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] i_req,
    input  logic [7:0]   i_last,
    output logic         o_valid,
    output logic [7:0]   o_idx
);

    int w_j;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_last;
        w_j     = 0;
        for (int k = N; k >= 1; k--) begin
            w_j = (int'(i_last) + k) % N;
            if (i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = 8'(w_j);
            end
        end
    end

endmodule

// File: rtl/bus_credit_arbiter.sv
// Round-robin packet-bus arbiter with per-destination credits.
// BUS_WRR_EN: allow up to max_burst packets per grant.
module bus_credit_arbiter
    import bus_arb_pkg::*;
#(
    parameter int         pckg_sz   = 32,
    parameter int         drvrs     = 16,
    parameter logic [7:0] broadcast = BCAST_DEF,
    parameter int         depth     = 8,
    parameter int         max_burst = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [pckg_sz-1:0]         D_push,
    output logic [drvrs-1:0]           push,
    input  logic [drvrs-1:0]           credit_rtn,
    output logic [7:0]                 grant_id,
    output logic                       busy,
    output logic [15:0]                drop_cnt
);

`ifdef BUS_WRR_EN
    localparam bit WRR = 1'b1;
`else
    localparam bit WRR = 1'b0;
`endif
    localparam int LIMIT = WRR ? max_burst : 1;
    localparam int CW    = $clog2(depth + 1);
    localparam int P_MSB = pckg_sz - 1;
    localparam int P_LSB = pckg_sz - DEST_W;

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_grant;
    logic [pckg_sz-1:0]   r_pkt;
    logic [15:0]          r_drop;
    logic [15:0]          r_burst;
    logic [CW-1:0]        r_cred [drvrs];

    logic                 w_pick_v;
    logic [7:0]           w_pick;
    logic [7:0]           w_dest;
    logic [drvrs-1:0]     w_self;
    logic [drvrs-1:0]     w_tgt;
    logic [drvrs-1:0]     w_has;
    logic [drvrs-1:0]     w_push;
    logic [pckg_sz-1:0]   w_head;
    logic                 w_drop;
    logic                 w_send;
    logic                 w_again;

    rr_pick #(.N(drvrs)) u_pick (
        .i_req   (pndng),
        .i_last  (r_grant),
        .o_valid (w_pick_v),
        .o_idx   (w_pick)
    );

    // Decode destination set and check credit availability.
    always_comb begin
        w_dest = r_pkt[P_MSB:P_LSB];
        w_self = '0;
        w_tgt  = '0;
        w_has  = '0;
        w_head = '0;
        for (int i = 0; i < drvrs; i++) begin
            w_self[i] = (r_grant == 8'(i));
            w_has[i]  = (r_cred[i] != '0);
            if (w_self[i]) w_head = D_pop[i*pckg_sz +: pckg_sz];
        end
        if (w_dest == broadcast) begin
            w_tgt = ~w_self;
        end else begin
            for (int i = 0; i < drvrs; i++)
                w_tgt[i] = (w_dest == 8'(i)) && !w_self[i];
        end
        w_drop = (w_tgt == '0);
        w_send = !w_drop && ((w_tgt & ~w_has) == '0);
        w_push = (r_state == DELIVER && w_send) ? w_tgt : '0;
    end

    // Next-state logic; a burst re-pops the same driver.
    always_comb begin
        w_next  = r_state;
        w_again = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_v) w_next = POP;
            end
            POP: begin
                w_next = DELIVER;
            end
            DELIVER: begin
                if (w_drop || w_send) begin
                    w_again = ((pndng & w_self) != '0)
                           && (r_burst < 16'(LIMIT));
                    w_next  = w_again ? POP : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, grant, packet capture and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= 8'(drvrs - 1);
            r_pkt   <= '0;
            r_drop  <= '0;
            r_burst <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_pick_v) begin
                r_grant <= w_pick;
                r_burst <= 16'd1;
            end
            if (w_again) r_burst <= r_burst + 16'd1;
            if (r_state == POP) r_pkt <= w_head;
            if (r_state == DELIVER && w_drop && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    // Credit counters: push consumes, return refills up to depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < drvrs; i++) r_cred[i] <= CW'(depth);
        end else begin
            for (int i = 0; i < drvrs; i++) begin
                if (w_push[i] && !credit_rtn[i])
                    r_cred[i] <= r_cred[i] - 1'b1;
                else if (!w_push[i] && credit_rtn[i]
                         && r_cred[i] != CW'(depth))
                    r_cred[i] <= r_cred[i] + 1'b1;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < drvrs; i++)
            pop[i] = (r_state == POP) && w_self[i];
    end

    assign push     = w_push;
    assign D_push   = r_pkt;
    assign grant_id = r_grant;
    assign busy     = (r_state != IDLE);
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_bus_credit_arbiter.sv
// Directed bench for bus_credit_arbiter with four drivers.
// Burst expectations follow BUS_WRR_EN when defined.
module tb_bus_credit_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     pndng;
    logic [N*W-1:0]   D_pop;
    logic [N-1:0]     pop;
    logic [W-1:0]     D_push;
    logic [N-1:0]     push;
    logic [N-1:0]     credit_rtn;
    logic [7:0]       grant_id;
    logic             busy;
    logic [15:0]      drop_cnt;

    int errs   = 0;
    int checks = 0;
    bit ok;

    always #5 clk = ~clk;

    bus_credit_arbiter #(
        .pckg_sz   (W),
        .drvrs     (N),
        .broadcast (8'hFF),
        .depth     (8),
        .max_burst (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pndng      (pndng),
        .D_pop      (D_pop),
        .pop        (pop),
        .D_push     (D_push),
        .push       (push),
        .credit_rtn (credit_rtn),
        .grant_id   (grant_id),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        pndng      = '0;
        credit_rtn = '0;
        D_pop      = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic set_pkt(input int i, input logic [31:0] v);
        D_pop[i*W +: W] = v;
    endtask

    task automatic wait_pop(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (pop != '0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("pop_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_rr [5];
        int exp_b [3];
        exp_rr = '{0, 1, 2, 3, 0};
`ifdef BUS_WRR_EN
        exp_b = '{0, 0, 1};
`else
        exp_b = '{0, 1, 0};
`endif

        // reset state
        do_reset();
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_dpush", D_push, 0);
        chk("rst_grant", grant_id, 3);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        for (int i = 0; i < N; i++)
            chk($sformatf("rst_cred%0d", i), dut.r_cred[i], 8);

        // single unicast 0 -> 2
        set_pkt(0, 32'h02AB_CDEF);
        pndng = 4'b0001;
        tick();
        chk("uni_pop", pop, 4'b0001);
        chk("uni_grant", grant_id, 0);
        chk("uni_busy", busy, 1);
        pndng = '0;
        tick();
        chk("uni_push", push, 4'b0100);
        chk("uni_dpush", D_push, 32'h02AB_CDEF);
        tick();
        chk("uni_push_off", push, 0);
        chk("uni_cred2", dut.r_cred[2], 7);
        chk("uni_idle", busy, 0);

        // round-robin fairness
        do_reset();
        for (int i = 0; i < N; i++)
            set_pkt(i, {8'((i + 1) % N), 24'h00_0000});
        pndng = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_pop(ok);
            chk($sformatf("rr_grant%0d", k), grant_id, exp_rr[k]);
            chk($sformatf("rr_pop%0d", k), pop, 4'b0001 << exp_rr[k]);
        end
        pndng = '0;

        // broadcast from driver 1
        do_reset();
        set_pkt(1, 32'hFF00_0011);
        pndng = 4'b0010;
        wait_pop(ok);
        chk("bc_pop", pop, 4'b0010);
        pndng = '0;
        tick();
        chk("bc_push", push, 4'b1101);
        chk("bc_dpush", D_push, 32'hFF00_0011);
        tick();
        chk("bc_push_once", push, 0);
        chk("bc_cred0", dut.r_cred[0], 7);
        chk("bc_cred1", dut.r_cred[1], 8);
        chk("bc_cred2", dut.r_cred[2], 7);
        chk("bc_cred3", dut.r_cred[3], 7);

        // credit stall on destination 3
        do_reset();
        set_pkt(0, 32'h0300_0000);
        pndng = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            wait_pop(ok);
            if (k == 8) pndng = '0;
            tick();
            if (k < 8) chk($sformatf("st_push%0d", k), push, 4'b1000);
        end
        chk("st_cred3_empty", dut.r_cred[3], 0);
        chk("st_stall_push", push, 0);
        chk("st_stall_busy", busy, 1);
        tick();
        tick();
        chk("st_still_push", push, 0);
        chk("st_still_busy", busy, 1);
        credit_rtn = 4'b1000;
        tick();
        credit_rtn = '0;
        chk("st_release", push, 4'b1000);
        tick();
        chk("st_done_push", push, 0);
        chk("st_done_busy", busy, 0);

        // asynchronous reset during a stall
        set_pkt(0, 32'h0300_0099);
        pndng = 4'b0001;
        wait_pop(ok);
        pndng = '0;
        tick();
        chk("ar_stall_busy", busy, 1);
        chk("ar_stall_push", push, 0);
        #1 reset = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_pop", pop, 0);
        chk("ar_push", push, 0);
        chk("ar_dpush", D_push, 0);
        chk("ar_grant", grant_id, 3);
        chk("ar_cred3", dut.r_cred[3], 8);
        tick();
        reset = 1'b1;

        // out-of-range and self-addressed drops
        do_reset();
        set_pkt(0, 32'h0900_0000);
        pndng = 4'b0001;
        wait_pop(ok);
        pndng = '0;
        tick();
        chk("inv_push", push, 0);
        tick();
        chk("inv_drop", drop_cnt, 1);
        chk("inv_idle", busy, 0);
        set_pkt(2, 32'h0200_0055);
        pndng = 4'b0100;
        wait_pop(ok);
        chk("self_pop", pop, 4'b0100);
        pndng = '0;
        tick();
        chk("self_push", push, 0);
        tick();
        chk("self_drop", drop_cnt, 2);

        // burst behaviour with two requesters
        do_reset();
        set_pkt(0, 32'h0100_0000);
        set_pkt(1, 32'h0200_0000);
        pndng = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            wait_pop(ok);
            chk($sformatf("burst_grant%0d", k), grant_id, exp_b[k]);
        end
        pndng = '0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
